// File: rtl/sdram_resp_pkg.sv
// Shared definitions for the SDRAM command responder: command encodings,
// bank states, read-pipeline word format and burst/CAS-latency decode.
package sdram_resp_pkg;

  localparam int unsigned DQ_W      = 16;
  localparam int unsigned BA_W      = 2;
  localparam int unsigned A_W       = 13;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned CL_MIN    = 2;
  localparam int unsigned CL_MAX    = 3;

  // {ras_n, cas_n, we_n} with cs_n low
  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_st_e;

  // One slot of the CAS-latency delay line
  typedef struct packed {
    logic            v;
    logic [DQ_W-1:0] d;
  } rd_word_t;

  // Burst length in words for mode code 0..3
  function automatic logic [3:0] bl_words(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

  // Column bits that wrap inside a burst
  function automatic logic [2:0] bl_mask(input logic [1:0] code);
    return 3'(bl_words(code) - 4'd1);
  endfunction

  // Mode word acceptable: BL code 0..3 and CL of 2 or 3
  function automatic logic mode_ok(input logic [A_W-1:0] a);
    return (a[2] == 1'b0) && ((a[6:4] == 3'(CL_MIN)) || (a[6:4] == 3'(CL_MAX)));
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store: one byte-enabled write port, one registered read port.
// Contents are never reset.
module sdram_resp_mem
  import sdram_resp_pkg::*;
#(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DQ_W-1:0]   wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DQ_W-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic [DQ_W-1:0] mem [DEPTH];

  // Byte-lane writes and a read that lands one cycle after the address
  always_ff @(posedge clk) begin
    if (we && be[0]) mem[waddr][7:0]  <= wdata[7:0];
    if (we && be[1]) mem[waddr][15:8] <= wdata[15:8];
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device-side responder: decodes bus commands, tracks bank state,
// runs read/write bursts against a backing store and counts protocol errors.
// Optional macro SDRAM_RESPONDER_TIMING_CHECK_EN adds tRCD/tRP/tRFC checks.
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter int unsigned COL_BITS = 9,
  parameter int unsigned ROW_BITS = 13,
  parameter int unsigned MEM_AW   = 12,
  parameter int unsigned T_RCD    = 2,
  parameter int unsigned T_RP     = 2,
  parameter int unsigned T_RFC    = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sdram_csn,
  input  logic            sdram_rasn,
  input  logic            sdram_casn,
  input  logic            sdram_wen,
  input  logic [A_W-1:0]  sdram_a,
  input  logic [BA_W-1:0] sdram_ba,
  input  logic [1:0]      sdram_dqm,
  input  logic [DQ_W-1:0] dq_i,
  output logic [DQ_W-1:0] dq_o,
  output logic            dq_oe,
  output logic [15:0]     err_cnt,
  output logic            err_pulse
);

  function automatic logic [MEM_AW-1:0] store_idx(input logic [BA_W-1:0] ba,
                                                  input logic [ROW_BITS-1:0] row,
                                                  input logic [COL_BITS-1:0] col);
    return MEM_AW'({ba, row, col});
  endfunction

  function automatic logic [COL_BITS-1:0] next_col(input logic [COL_BITS-1:0] col,
                                                   input logic [1:0] code);
    logic [COL_BITS-1:0] m;
    m = COL_BITS'(bl_mask(code));
    return (col & ~m) | ((col + COL_BITS'(1)) & m);
  endfunction

  cmd_e                cmd;
  bank_st_e            bank_st  [NUM_BANKS];
  logic [ROW_BITS-1:0] bank_row [NUM_BANKS];
  logic [1:0]          bl_code;
  logic                cl3;
  logic                bst_act, bst_wr, bst_ap;
  logic [BA_W-1:0]     bst_ba;
  logic [ROW_BITS-1:0] bst_row;
  logic [COL_BITS-1:0] bst_col;
  logic [2:0]          bst_rem;
  logic                any_act, func_err, time_err, err_c, rw_ok, term, ap_close;
  logic                mem_we, mem_re, rd_v;
  logic [MEM_AW-1:0]   mem_addr;
  logic [DQ_W-1:0]     rdata;
  rd_word_t            pipe0, pipe1, rd_sel;

  // Command decode, functional error detection and store port steering
  always_comb begin
    cmd      = sdram_csn ? CMD_NOP : cmd_e'({sdram_rasn, sdram_casn, sdram_wen});
    func_err = 1'b0;
    rw_ok    = 1'b0;
    any_act  = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) any_act = any_act | (bank_st[i] == BANK_ACTIVE);
    case (cmd)
      CMD_ACT:        func_err = (bank_st[sdram_ba] == BANK_ACTIVE);
      CMD_RD, CMD_WR: begin
        func_err = (bank_st[sdram_ba] == BANK_IDLE);
        rw_ok    = (bank_st[sdram_ba] == BANK_ACTIVE);
      end
      CMD_REF:        func_err = any_act;
      CMD_LMR:        func_err = !mode_ok(sdram_a);
      default:        ;
    endcase
    term = bst_act && (rw_ok || (cmd == CMD_BST) ||
                       ((cmd == CMD_PRE) && (sdram_a[10] || (sdram_ba == bst_ba))));
    ap_close = bst_act && bst_ap && (term || (bst_rem == 3'd0));
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = '0;
    if (rw_ok) begin
      mem_addr = store_idx(sdram_ba, bank_row[sdram_ba], sdram_a[COL_BITS-1:0]);
      mem_we   = (cmd == CMD_WR);
      mem_re   = (cmd == CMD_RD);
    end else if (bst_act && !term) begin
      mem_addr = store_idx(bst_ba, bst_row, bst_col);
      mem_we   = bst_wr;
      mem_re   = !bst_wr;
    end
    err_c = func_err | time_err;
  end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] rcd_cnt [NUM_BANKS];
  logic [CNT_W-1:0] rp_cnt  [NUM_BANKS];
  logic [CNT_W-1:0] rfc_cnt;

  // Spacing violations against the per-bank and refresh countdowns
  always_comb begin
    time_err = 1'b0;
    case (cmd)
      CMD_RD, CMD_WR: time_err = (rcd_cnt[sdram_ba] != '0);
      CMD_ACT:        time_err = (rp_cnt[sdram_ba] != '0);
      default:        ;
    endcase
    if ((cmd != CMD_NOP) && (rfc_cnt != '0)) time_err = 1'b1;
  end

  // Countdowns reload on the accepted command and run down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        rcd_cnt[i] <= '0;
        rp_cnt[i]  <= '0;
      end
      rfc_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (rcd_cnt[i] != '0) rcd_cnt[i] <= rcd_cnt[i] - CNT_W'(1);
        if (rp_cnt[i] != '0)  rp_cnt[i]  <= rp_cnt[i] - CNT_W'(1);
        if ((cmd == CMD_PRE) && (sdram_a[10] || (sdram_ba == BA_W'(i))))
          rp_cnt[i] <= CNT_W'(T_RP - 1);
      end
      if (rfc_cnt != '0) rfc_cnt <= rfc_cnt - CNT_W'(1);
      if ((cmd == CMD_ACT) && !func_err) rcd_cnt[sdram_ba] <= CNT_W'(T_RCD - 1);
      if ((cmd == CMD_REF) && !func_err) rfc_cnt <= CNT_W'(T_RFC - 1);
    end
  end
`else
  assign time_err = 1'b0;

  // Spacing parameters only take effect when timing checks are built in
  if ((T_RCD + T_RP + T_RFC) == 0) begin : g_no_spacing
  end
`endif

  // Bank state, mode register and burst sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_st[i]  <= BANK_IDLE;
        bank_row[i] <= '0;
      end
      bl_code <= 2'd0;
      cl3     <= 1'b0;
      bst_act <= 1'b0;
      bst_wr  <= 1'b0;
      bst_ap  <= 1'b0;
      bst_ba  <= '0;
      bst_row <= '0;
      bst_col <= '0;
      bst_rem <= '0;
    end else begin
      if (ap_close) bank_st[bst_ba] <= BANK_IDLE;
      if (rw_ok) begin
        bst_act <= (bl_code != 2'd0);
        bst_wr  <= (cmd == CMD_WR);
        bst_ap  <= sdram_a[10];
        bst_ba  <= sdram_ba;
        bst_row <= bank_row[sdram_ba];
        bst_col <= next_col(sdram_a[COL_BITS-1:0], bl_code);
        bst_rem <= 3'(bl_words(bl_code) - 4'd2);
        if ((bl_code == 2'd0) && sdram_a[10]) bank_st[sdram_ba] <= BANK_IDLE;
      end else if (term) begin
        bst_act <= 1'b0;
      end else if (bst_act) begin
        if (bst_rem == 3'd0) begin
          bst_act <= 1'b0;
        end else begin
          bst_rem <= bst_rem - 3'd1;
          bst_col <= next_col(bst_col, bl_code);
        end
      end
      if (!func_err) begin
        case (cmd)
          CMD_ACT: begin
            bank_st[sdram_ba]  <= BANK_ACTIVE;
            bank_row[sdram_ba] <= sdram_a[ROW_BITS-1:0];
          end
          CMD_PRE: begin
            for (int i = 0; i < NUM_BANKS; i++)
              if (sdram_a[10] || (sdram_ba == BA_W'(i))) bank_st[i] <= BANK_IDLE;
          end
          CMD_LMR: begin
            bl_code <= sdram_a[1:0];
            cl3     <= (sdram_a[6:4] == 3'(CL_MAX));
          end
          default: ;
        endcase
      end
    end
  end

  sdram_resp_mem #(.MEM_AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (~sdram_dqm),
    .waddr (mem_addr),
    .wdata (dq_i),
    .raddr (mem_addr),
    .rdata (rdata)
  );

  assign rd_sel = cl3 ? pipe1 : pipe0;

  // CAS-latency delay line feeding the registered data outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v  <= 1'b0;
      pipe0 <= '0;
      pipe1 <= '0;
      dq_oe <= 1'b0;
      dq_o  <= '0;
    end else begin
      rd_v  <= mem_re;
      pipe0 <= {rd_v, rdata};
      pipe1 <= pipe0;
      dq_oe <= rd_sel.v;
      dq_o  <= rd_sel.v ? rd_sel.d : '0;
    end
  end

  // Saturating error counter and one-cycle error strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_c;
      if (err_c && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder with a scoreboard on the read data bus.
module tb_sdram_responder;
  import sdram_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csn, rasn, casn, wen;
  logic [12:0] a;
  logic [1:0]  ba, dqm;
  logic [15:0] dq_i, dq_o, err_cnt;
  logic        dq_oe, err_pulse;

  typedef struct {
    int          cyc;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   last_edge = 0;
  int   pulse_cnt = 0;
  int   exp_err   = 0;
  int   e0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sdram_csn  (csn),
    .sdram_rasn (rasn),
    .sdram_casn (casn),
    .sdram_wen  (wen),
    .sdram_a    (a),
    .sdram_ba   (ba),
    .sdram_dqm  (dqm),
    .dq_i       (dq_i),
    .dq_o       (dq_o),
    .dq_oe      (dq_oe),
    .err_cnt    (err_cnt),
    .err_pulse  (err_pulse)
  );

  task automatic drive(input cmd_e c, input logic [1:0] b, input logic [12:0] addr,
                       input logic [15:0] d, input logic [1:0] m);
    @(negedge clk);
    csn              = (c == CMD_NOP);
    {rasn, casn, wen} = c;
    ba               = b;
    a                = addr;
    dq_i             = d;
    dqm              = m;
    last_edge        = cyc + 1;
  endtask

  task automatic cmd(input cmd_e c, input logic [1:0] b, input logic [12:0] addr);
    drive(c, b, addr, 16'h0000, 2'b00);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drive(CMD_NOP, 2'd0, 13'd0, 16'h0000, 2'b00);
  endtask

  task automatic push(input int at, input logic [15:0] d);
    exp_t e;
    e.cyc = at;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every driven read word must match the next expected
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      n_tests++;
      if (dq_oe) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: dq_o=0x%0h at cycle %0d, required dq_oe=0", dq_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if ((dq_o !== e.d) || (cyc != e.cyc)) begin
            n_fail++;
            $display("FAIL read_word: got 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                     dq_o, cyc, e.d, e.cyc);
          end
        end
      end else if (dq_o !== 16'h0000) begin
        n_fail++;
        $display("FAIL dq_idle: got 0x%0h with dq_oe=0, required 0x0", dq_o);
      end
      if (err_pulse) pulse_cnt++;
    end
  end

  initial begin
    rst_n = 1'b0;
    csn = 1'b1; rasn = 1'b1; casn = 1'b1; wen = 1'b1;
    a = '0; ba = '0; dqm = '0; dq_i = '0;
    repeat (3) @(negedge clk);
    check("rst_dq_oe", 32'(dq_oe), 32'd0);
    check("rst_dq_o", 32'(dq_o), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_err_pulse", 32'(err_pulse), 32'd0);
    rst_n = 1'b1;

    // BL1 CL2 single write then read
    cmd(CMD_LMR, 2'd0, 13'h020);
    cmd(CMD_ACT, 2'd0, 13'd5);
    nop(2);
    drive(CMD_WR, 2'd0, 13'd8, 16'h1234, 2'b00);
    nop(1);
    cmd(CMD_RD, 2'd0, 13'd8);
    push(last_edge + 2, 16'h1234);
    nop(4);

    // BL8 CL3 wrapping burst: column 5 start, then column 0 start
    cmd(CMD_LMR, 2'd0, 13'h033);
    drive(CMD_WR, 2'd0, 13'd5, 16'h0000, 2'b00);
    for (int k = 1; k < 8; k++) drive(CMD_NOP, 2'd0, 13'd0, 16'(k), 2'b00);
    nop(1);
    cmd(CMD_RD, 2'd0, 13'd5);
    for (int k = 0; k < 8; k++) push(last_edge + 3 + k, 16'(k));
    nop(9);
    cmd(CMD_RD, 2'd0, 13'd0);
    for (int k = 0; k < 8; k++) push(last_edge + 3 + k, 16'((k + 3) % 8));
    nop(11);

    // Byte mask: low byte kept from first write
    cmd(CMD_LMR, 2'd0, 13'h020);
    drive(CMD_WR, 2'd0, 13'd20, 16'hAAAA, 2'b00);
    drive(CMD_WR, 2'd0, 13'd20, 16'h5555, 2'b01);
    cmd(CMD_RD, 2'd0, 13'd20);
    push(last_edge + 2, 16'h55AA);
    nop(4);

    // READ to idle bank 2
    check("err_before_idle_read", 32'(err_cnt), 32'd0);
    cmd(CMD_RD, 2'd2, 13'd0);
    nop(3);
    exp_err = 1;
    check("err_idle_read", 32'(err_cnt), 32'(exp_err));
    check("pulse_idle_read", 32'(pulse_cnt), 32'(exp_err));
    check("oe_idle_read", 32'(dq_oe), 32'd0);

    // BL4 read cut by BURST TERMINATE after two words
    cmd(CMD_LMR, 2'd0, 13'h022);
    drive(CMD_WR, 2'd0, 13'd16, 16'h00A0, 2'b00);
    for (int k = 1; k < 4; k++) drive(CMD_NOP, 2'd0, 13'd0, 16'(16'h00A0 + k), 2'b00);
    nop(1);
    cmd(CMD_RD, 2'd0, 13'd16);
    e0 = last_edge;
    nop(1);
    cmd(CMD_BST, 2'd0, 13'd0);
    push(e0 + 2, 16'h00A0);
    push(e0 + 3, 16'h00A1);
    nop(5);
    check("oe_after_bst", 32'(dq_oe), 32'd0);

    // Auto-precharge read closes bank 0
    cmd(CMD_RD, 2'd0, 13'h410);
    for (int k = 0; k < 4; k++) push(last_edge + 2 + k, 16'(16'h00A0 + k));
    nop(5);
    cmd(CMD_RD, 2'd0, 13'd16);
    nop(3);
    exp_err = 2;
    check("err_after_autopre", 32'(err_cnt), 32'(exp_err));

    // Illegal CAS latency rejected, mode stays BL4 CL2
    cmd(CMD_LMR, 2'd0, 13'h040);
    cmd(CMD_ACT, 2'd0, 13'd5);
    nop(2);
    cmd(CMD_RD, 2'd0, 13'd16);
    for (int k = 0; k < 4; k++) push(last_edge + 2 + k, 16'(16'h00A0 + k));
    nop(6);
    exp_err = 3;
    check("err_bad_mode", 32'(err_cnt), 32'(exp_err));

    // WRITE one cycle after ACTIVE
    cmd(CMD_ACT, 2'd1, 13'd3);
    drive(CMD_WR, 2'd1, 13'd0, 16'h00B0, 2'b00);
    for (int k = 1; k < 4; k++) drive(CMD_NOP, 2'd0, 13'd0, 16'(16'h00B0 + k), 2'b00);
    nop(1);
    cmd(CMD_RD, 2'd1, 13'd0);
    for (int k = 0; k < 4; k++) push(last_edge + 2 + k, 16'(16'h00B0 + k));
    nop(6);
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    exp_err = exp_err + 1;
`endif
    check("err_trcd", 32'(err_cnt), 32'(exp_err));

    // REFRESH with banks open, then legal refresh after precharge-all
    cmd(CMD_REF, 2'd0, 13'd0);
    nop(2);
    exp_err = exp_err + 1;
    check("err_ref_active", 32'(err_cnt), 32'(exp_err));
    cmd(CMD_PRE, 2'd0, 13'h400);
    nop(2);
    cmd(CMD_REF, 2'd0, 13'd0);
    nop(8);
    check("err_ref_idle", 32'(err_cnt), 32'(exp_err));
    check("pulse_total", 32'(pulse_cnt), 32'(exp_err));

    // Reset in the middle of a read burst
    cmd(CMD_ACT, 2'd0, 13'd5);
    nop(2);
    cmd(CMD_RD, 2'd0, 13'd16);
    nop(2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    pulse_cnt = 0;
    exp_err   = 0;
    check("midrst_dq_oe", 32'(dq_oe), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    nop(10);
    check("post_rst_err", 32'(err_cnt), 32'd0);
    cmd(CMD_RD, 2'd0, 13'd16);
    nop(3);
    exp_err = 1;
    check("post_rst_bank_idle", 32'(err_cnt), 32'(exp_err));
    check("post_rst_pulse", 32'(pulse_cnt), 32'(exp_err));

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter COL_BITS, default 9, column address width (8/9/10).
REQ-002 SHALL have parameter ROW_BITS, default 13, row address width (12/13).
REQ-003 SHALL have parameter MEM_AW, default 12, backing-store word-address width.
REQ-004 SHALL have parameters T_RCD=2, T_RP=2, T_RFC=7, minimum spacings in clk cycles.
REQ-005 SHALL have port clk, input, 1, the sole clock (the chip clock), rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have ports sdram_csn, sdram_rasn, sdram_casn, sdram_wen, each input, 1, command strobes, active-low.
REQ-008 SHALL have port sdram_a, input, 13, address; sdram_ba, input, 2, bank; sdram_dqm, input, 2, byte masks, [0]=low byte.
REQ-009 SHALL have port dq_i, input, 16, write data; dq_o, output, 16, read data; dq_oe, output, 1, read drive enable.
REQ-010 SHALL have port err_cnt, output, 16, saturating protocol-error count; err_pulse, output, 1, one-cycle pulse per error.

Function
REQ-011 SHALL decode a command every cycle: csn=1 or {ras,cas,we}=111 -> NOP; 011 ACTIVE; 101 READ; 100 WRITE; 010 PRECHARGE (a[10]=1 all banks); 001 REFRESH; 000 LOAD MODE; 110 BURST TERMINATE.
REQ-012 SHALL keep per bank state IDLE/ACTIVE plus open row; ACTIVE latches the row, PRECHARGE returns the bank to IDLE.
REQ-013 SHALL on LOAD MODE latch BL from a[2:0] (0..3 -> 1,2,4,8) and CL from a[6:4] (2 or 3); other codes -> error, mode unchanged.
REQ-014 SHALL map each word to store index = low MEM_AW bits of {ba,row,col}; aliasing above that is permitted.
REQ-015 SHALL on WRITE store dq_i in the command cycle and BL-1 following cycles; a byte with dqm=1 is not written.
REQ-016 SHALL on READ drive dq_oe=1 and dq_o with the first word exactly CL cycles after the command, then one word per cycle for BL words.
REQ-017 SHALL sequence burst columns sequentially, wrapping within the BL-aligned column block.
REQ-018 SHALL terminate an in-flight burst on a new READ, WRITE, BURST TERMINATE or PRECHARGE of that bank; read words already in the CL pipeline still emerge.
REQ-019 SHALL honour a[10]=1 on READ/WRITE as auto-precharge: bank goes IDLE after the final burst word.
REQ-020 SHALL flag as error, without touching memory: READ/WRITE to an IDLE bank, ACTIVE to an ACTIVE bank, REFRESH with any bank ACTIVE.
REQ-021 SHALL increment err_cnt by one per error cycle, saturating at 16'hFFFF; err_pulse asserted in the cycle after detection.
REQ-022 SHALL drive dq_o=0 whenever dq_oe=0.

Reset
REQ-023 SHALL on rst_n=0 set all banks IDLE, BL=1, CL=2, bursts and read pipeline cleared, dq_oe=0, dq_o=0, err_cnt=0, err_pulse=0; store contents are not cleared.
REQ-024 SHALL abandon any burst on reset assertion mid-burst; no further read words appear after release.

Configuration
REQ-025 SHALL with SDRAM_RESPONDER_TIMING_CHECK_EN defined count as errors ACTIVE->READ/WRITE closer than T_RCD, PRECHARGE->ACTIVE closer than T_RP, REFRESH->any command closer than T_RFC (per-bank counters); without it these checks and counters are absent and only REQ-020 errors count.

Structure
REQ-026 SHALL take command encodings, bank-state enum and BL/CL decode constants from shared package sdram_resp_pkg.
REQ-027 SHALL place the backing store in sub-module sdram_resp_mem: 2^MEM_AW x 16, one write port with 2-bit byte enables, one registered read port.

Verification
REQ-028 SHALL cover: LOAD MODE a=0x020, ACTIVE b0 r5, WRITE c8 data 0x1234, READ c8 -> dq_oe=1, dq_o=0x1234 exactly 2 cycles after READ.
REQ-029 SHALL cover: mode 0x033 (CL3 BL8), WRITE c5 data 0..7, READ c5 -> words 0..7 in column order 5,6,7,0,1,2,3,4 starting 3 cycles later.
REQ-030 SHALL cover: WRITE 0xAAAA then WRITE 0x5555 with dqm=01, READ -> 0x55AA.
REQ-031 SHALL cover: READ to IDLE bank 2 -> err_cnt 0->1, one err_pulse, dq_oe stays 0.
REQ-032 SHALL cover: BL4 READ interrupted after 2 words by BURST TERMINATE -> exactly 2 words driven, then dq_oe=0.
REQ-033 SHALL cover (with macro): ACTIVE then READ 1 cycle later -> err_cnt=1; without macro -> err_cnt=0.
